// File: rtl/svc_rv_perf_cnt.sv
// Performance counter block: free-running CYCLE, INSTRET and NUM_EVENTS event counters
// behind a small MMIO window with a lo-read/hi-shadow snapshot scheme.
module svc_rv_perf_cnt #(
    parameter int unsigned NUM_EVENTS = 4,
    parameter int unsigned CNT_WIDTH  = 48,
    parameter int unsigned AW         = 8,
    parameter bit          EN_RST     = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  retire,
    input  logic [NUM_EVENTS-1:0] event_vec,
    input  logic                  io_ren,
    input  logic [31:0]           io_raddr,
    output logic [31:0]           io_rdata,
    input  logic                  io_wen,
    input  logic [31:0]           io_waddr,
    input  logic [31:0]           io_wdata,
    input  logic [3:0]            io_wstrb
);

    localparam int unsigned NC = NUM_EVENTS + 2;
    localparam int unsigned SW = CNT_WIDTH - 32;
    localparam int unsigned WW = AW - 2;

    logic [CNT_WIDTH-1:0] cnt_q [NC];
    logic [CNT_WIDTH-1:0] cnt_d [NC];
    logic [NC-1:0]        status_q, status_d;
    logic [NC-1:0]        inc, wrap, w1c;
    logic                 enable_q, enable_d;
    logic                 clear;
    logic [SW-1:0]        shadow_q, shadow_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [WW-1:0]        rword, wword;

    assign rword    = io_raddr[AW-1:2];
    assign wword    = io_waddr[AW-1:2];
    assign inc      = {event_vec, retire, 1'b1};
    assign io_rdata = rdata_q;

    always_comb begin
        enable_d = enable_q;
        clear    = 1'b0;
        w1c      = '0;
        if (io_wen && io_wstrb[0] && wword == WW'(0)) begin
            enable_d = io_wdata[0];
            clear    = io_wdata[1];
        end
        if (io_wen && wword == WW'(1)) begin
            for (int k = 0; k < int'(NC); k++) begin
                w1c[k] = io_wdata[k] & io_wstrb[k/8];
            end
        end
    end

    // Clear takes priority over any increment landing on the same edge.
    always_comb begin
        for (int k = 0; k < int'(NC); k++) begin
            cnt_d[k] = cnt_q[k];
            wrap[k]  = 1'b0;
            if (clear) begin
                cnt_d[k] = '0;
            end else if (enable_q && inc[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                wrap[k]  = &cnt_q[k];
            end
        end
        status_d = (status_q & ~w1c) | wrap;
    end

    // Reads see pre-edge state; a lo read snapshots the upper bits for the hi read.
    always_comb begin
        rdata_d  = rdata_q;
        shadow_d = shadow_q;
        if (io_ren) begin
            rdata_d = '0;
            if (rword == WW'(0)) begin
                rdata_d = {31'b0, enable_q};
            end else if (rword == WW'(1)) begin
                rdata_d = 32'(status_q);
            end
            for (int k = 0; k < int'(NC); k++) begin
                if (rword == WW'(2 + 2 * k)) begin
                    rdata_d  = cnt_q[k][31:0];
                    shadow_d = cnt_q[k][CNT_WIDTH-1:32];
                end else if (rword == WW'(3 + 2 * k)) begin
                    rdata_d = 32'(shadow_q);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '{default: '0};
            status_q <= '0;
            enable_q <= EN_RST;
            shadow_q <= '0;
            rdata_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            status_q <= status_d;
            enable_q <= enable_d;
            shadow_q <= shadow_d;
            rdata_q  <= rdata_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{io_raddr[31:AW], io_raddr[1:0], io_waddr[31:AW], io_waddr[1:0],
                           io_wdata, io_wstrb};

endmodule

// File: doc/svc_rv_perf_cnt.md
SVC_RV_PERF_CNT -- requirements
Module: svc_rv_perf_cnt

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 4: number of generic event counters (1..8).
REQ-002 SHALL have parameter CNT_WIDTH, default 48: counter width in bits (33..64).
REQ-003 SHALL have parameter AW, default 8: byte-address bits decoded from io_raddr/io_waddr.
REQ-004 SHALL have parameter EN_RST, default 1: reset value of CTRL.enable.
REQ-005 SHALL have ports clk  input  1  clock; rst_n  input  1  reset; one clock, asynchronous active-low reset.
REQ-006 SHALL have port retire  input  1  one instruction retired this cycle.
REQ-007 SHALL have port event_vec  input  NUM_EVENTS  per-counter event strobes.
REQ-008 SHALL have ports io_ren  input  1; io_raddr  input  32; io_rdata  output  32: MMIO read.
REQ-009 SHALL have ports io_wen  input  1; io_waddr  input  32; io_wdata  input  32; io_wstrb  input  4: MMIO write.

Function
REQ-010 SHALL decode word offset addr[AW-1:2]; upper address bits ignored.
REQ-011 SHALL map: 0x00 CTRL (bit0 enable, bit1 clear); 0x04 STATUS (overflow bit per counter); 0x08/0x0C CYCLE lo/hi; 0x10/0x14 INSTRET lo/hi; 0x18+8*i / 0x1C+8*i EVENT[i] lo/hi.
REQ-012 SHALL count CYCLE every cycle, INSTRET when retire, EVENT[i] when event_vec[i]; each only while enable=1, +1 per cycle maximum.
REQ-013 SHALL wrap a counter from 2^CNT_WIDTH-1 to 0 and set its sticky STATUS bit in the same cycle (STATUS bit order: 0 CYCLE, 1 INSTRET, 2+i EVENT[i]).
REQ-014 SHALL treat CTRL.clear as write-one self-clearing: zeroes all counters on the next edge, reads back 0; clear beats same-cycle increment.
REQ-015 SHALL clear STATUS bits written with 1 (W1C); a same-cycle wrap sets the bit (set wins).
REQ-016 SHALL apply writes only to bytes with io_wstrb set; CTRL/STATUS use byte 0 only; counter registers are read-only, writes ignored.
REQ-017 SHALL return io_rdata one cycle after io_ren, holding it until the next io_ren.
REQ-018 SHALL return lo reads as counter[31:0] sampled in the io_ren cycle (pre-increment) and latch counter[CNT_WIDTH-1:32] into a single shadow register in the same cycle.
REQ-019 SHALL return hi reads from the shadow, zero-extended; hi read without prior lo read returns the last latched shadow.
REQ-020 SHALL return 0 for unmapped or beyond-NUM_EVENTS addresses with no side effect.
REQ-021 SHALL give a read and write to the same register in one cycle the pre-write value.
REQ-022 SHALL keep counters frozen, not reset, when enable=0; re-enable resumes from held value.

Reset
REQ-023 SHALL on rst_n=0 asynchronously set all counters, STATUS, shadow, io_rdata to 0 and enable to EN_RST.
REQ-024 SHALL, when reset asserts mid-count or mid lo/hi read pair, discard the pair; first post-reset hi read returns 0.
REQ-025 SHALL start counting on the first rising edge after rst_n deasserts.

Verification
REQ-026 Reset release, enable=1, 100 cycles idle, read CYCLE lo -> value within 100..102; INSTRET reads 0.
REQ-027 retire high 37 cycles then low, read INSTRET lo -> 37; write CTRL=0x3 -> all counters 0 next cycle, enable stays 1.
REQ-028 CNT_WIDTH=33, EVENT[0] preloaded near wrap via 2^33 events -> wraps to 0, STATUS bit2=1; write STATUS=0x4 -> bit2=0.
REQ-029 CYCLE at 0x0_FFFF_FFFF: read lo returns 0xFFFFFFFF, following hi read returns 0x0 though counter is now 0x1_0000_xxxx.
REQ-030 CTRL=0 with retire high 10 cycles -> INSTRET unchanged; re-enable -> increments resume; read 0x3C (NUM_EVENTS=4) -> 0.
REQ-031 rst_n pulsed low mid-count between lo and hi reads -> all reads return 0, enable=EN_RST.
